// File: rtl/arbitro_mult_if.sv
// Bundle of requester, response and multiplier-side signals for arbitro_mult.
// The slave view is the arbiter itself; the master view is its surroundings
// (requesters, response consumer and the ss_mult instance).
interface arbitro_mult_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_A;
  logic [N_REQ*WIDTH-1:0] req_B;
  logic [N_REQ-1:0]       req_ready;

  logic                   resp_valid;
  logic                   resp_ready;
  logic [IDW-1:0]         resp_id;
  logic [2*WIDTH-1:0]     resp_result;
  logic                   resp_error;

  logic                   mult_valid;
  logic [WIDTH-1:0]       mult_A;
  logic [WIDTH-1:0]       mult_B;
  logic                   mult_done;
  logic [2*WIDTH-1:0]     mult_result;

  modport slave (
    input  req_valid, req_A, req_B, resp_ready, mult_done, mult_result,
    output req_ready, resp_valid, resp_id, resp_result, resp_error,
           mult_valid, mult_A, mult_B
  );

  modport master (
    output req_valid, req_A, req_B, resp_ready, mult_done, mult_result,
    input  req_ready, resp_valid, resp_id, resp_result, resp_error,
           mult_valid, mult_A, mult_B
  );
endinterface

// File: rtl/arbitro_mult.sv
// Round-robin arbiter that shares one ss_mult between N_REQ requesters.
// One transaction is in flight at a time: accept, pulse start, wait for done
// (or give up after TIMEOUT cycles), then hold the tagged response until taken.
module arbitro_mult #(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic          clk,
  input  logic          rst,
  arbitro_mult_if.slave bus,
  output logic          busy
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDW-1:0]     last_grant;
  logic [TW-1:0]      timer;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [IDW-1:0]     id_q;
  logic [2*WIDTH-1:0] result_q;
  logic               error_q;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic               timeout_hit;

  assign timeout_hit     = (timer == TW'(TIMEOUT - 1));
  assign bus.mult_A      = op_a;
  assign bus.mult_B      = op_b;
  assign bus.resp_id     = id_q;
  assign bus.resp_result = result_q;
  assign bus.resp_error  = error_q;

  // Pick the first requesting index after the last one served, wrapping round.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_grant) + k) % N_REQ;
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // State register; reset drops any transaction in flight without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision and the state-decoded handshake outputs.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.mult_valid = 1'b0;
    bus.resp_valid = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_found) begin
          bus.req_ready[grant_idx] = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.mult_valid = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.mult_done || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/ID capture, wait timer, response payload and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDW'(N_REQ - 1);
      timer      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      id_q       <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a <= bus.req_A[grant_idx*WIDTH +: WIDTH];
            op_b <= bus.req_B[grant_idx*WIDTH +: WIDTH];
            id_q <= grant_idx;
          end
        end
        ISSUE: begin
          timer <= '0;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (bus.mult_done) begin
            result_q <= bus.mult_result;
            error_q  <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= '0;
            error_q  <= 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) last_grant <= id_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_mult.sv
// Bench for arbitro_mult: a behavioural ss_mult stand-in plus a round-robin
// and signed-product reference model drive directed and random transactions.
module tb_arbitro_mult;
  localparam int N_REQ   = 2;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 31;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  arbitro_mult_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  arbitro_mult #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in controls
  bit                 never_done;
  int                 latency;
  logic               late_done;
  logic               stub_done;
  logic               stub_pending;
  int                 stub_cnt;
  logic [2*WIDTH-1:0] stub_res;
  logic [2*WIDTH-1:0] stub_prod;

  assign bus.mult_done   = stub_done | late_done;
  assign bus.mult_result = late_done ? 8'h5A : stub_res;

  // Stand-in for ss_mult: answers a start pulse after 'latency' extra cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_done    <= 1'b0;
      stub_pending <= 1'b0;
      stub_cnt     <= 0;
      stub_res     <= '0;
      stub_prod    <= '0;
    end else begin
      stub_done <= 1'b0;
      if (stub_pending) begin
        if (stub_cnt == 0) begin
          stub_done    <= 1'b1;
          stub_res     <= stub_prod;
          stub_pending <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end else if (bus.mult_valid && !never_done) begin
        stub_pending <= 1'b1;
        stub_cnt     <= latency;
        stub_prod    <= $signed({{WIDTH{bus.mult_A[WIDTH-1]}}, bus.mult_A}) *
                        $signed({{WIDTH{bus.mult_B[WIDTH-1]}}, bus.mult_B});
      end
    end
  end

  int n_vec;
  int n_err;
  int model_last;

  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] mask);
    for (int off = 1; off <= N_REQ; off++) begin
      int c;
      c = (last + off) % N_REQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [2*WIDTH-1:0] sext_mul(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    int ia;
    int ib;
    ia = int'(a) - (a[WIDTH-1] ? (1 << WIDTH) : 0);
    ib = int'(b) - (b[WIDTH-1] ? (1 << WIDTH) : 0);
    return (2*WIDTH)'(ia * ib);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int r, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
    bus.req_valid[r]           = 1'b1;
    bus.req_A[r*WIDTH +: WIDTH] = a;
    bus.req_B[r*WIDTH +: WIDTH] = b;
  endtask

  // Runs one full transaction starting in IDLE with requests already driven.
  task automatic serve_one(input int hold, input bit keep_valid, input bit exp_timeout,
                           output int got_id, output logic [2*WIDTH-1:0] got_res);
    int               g;
    int               waited;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2*WIDTH-1:0] exp_res;
    got_id  = -1;
    got_res = '0;
    #1;
    g = rr_pick(model_last, bus.req_valid);
    if (g < 0) begin
      n_vec++;
      n_err++;
      $error("[TB] FAIL no_request: observed none expected a pending request");
      return;
    end
    check_output("req_ready_onehot", 32'(bus.req_ready), 32'(1 << g));
    check_output("busy_idle", 32'(busy), 0);
    a = bus.req_A[g*WIDTH +: WIDTH];
    b = bus.req_B[g*WIDTH +: WIDTH];
    exp_res = exp_timeout ? '0 : sext_mul(a, b);
    tick();
    if (keep_valid) begin
      bus.req_A[g*WIDTH +: WIDTH] = WIDTH'($urandom);
      bus.req_B[g*WIDTH +: WIDTH] = WIDTH'($urandom);
    end else begin
      bus.req_valid[g] = 1'b0;
    end
    #1;
    check_output("mult_valid_issue", 32'(bus.mult_valid), 1);
    check_output("req_ready_issue", 32'(bus.req_ready), 0);
    check_output("mult_A", 32'(bus.mult_A), 32'(a));
    check_output("mult_B", 32'(bus.mult_B), 32'(b));
    tick();
    check_output("mult_valid_pulse", 32'(bus.mult_valid), 0);
    waited = 0;
    while (!bus.resp_valid && waited < 60) begin
      tick();
      waited++;
    end
    check_output("resp_latency", 32'(waited), exp_timeout ? TIMEOUT : latency + 2);
    if (!bus.resp_valid) return;
    check_output("resp_id", 32'(bus.resp_id), 32'(g));
    check_output("resp_result", 32'(bus.resp_result), 32'(exp_res));
    check_output("resp_error", 32'(bus.resp_error), 32'(exp_timeout));
    check_output("req_ready_resp", 32'(bus.req_ready), 0);
    got_id  = int'(bus.resp_id);
    got_res = bus.resp_result;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) late_done = 1'b1;
      tick();
      late_done = 1'b0;
      #1;
      check_output("hold_valid", 32'(bus.resp_valid), 1);
      check_output("hold_id", 32'(bus.resp_id), 32'(g));
      check_output("hold_result", 32'(bus.resp_result), 32'(exp_res));
      check_output("hold_error", 32'(bus.resp_error), 32'(exp_timeout));
      check_output("hold_req_ready", 32'(bus.req_ready), 0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    #1;
    check_output("resp_dropped", 32'(bus.resp_valid), 0);
    check_output("back_to_idle", 32'(busy), 0);
    model_last = g;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = N_REQ - 1;
    #1;
  endtask

  // Hard stop in case the sequence stalls somewhere unexpected.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no finish expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int id;
    logic [2*WIDTH-1:0] res;
    n_vec = 0;
    n_err = 0;
    never_done = 1'b0;
    latency = 0;
    late_done = 1'b0;
    bus.req_valid = '0;
    bus.req_A = '0;
    bus.req_B = '0;
    bus.resp_ready = 1'b0;
    model_last = N_REQ - 1;
    rst = 1'b1;
    #12;
    check_output("rst_req_ready", 32'(bus.req_ready), 0);
    check_output("rst_resp_valid", 32'(bus.resp_valid), 0);
    check_output("rst_mult_valid", 32'(bus.mult_valid), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_resp_payload", {bus.resp_id, bus.resp_result, bus.resp_error}, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single request");
    apply_stimulus(0, 4'b0011, 4'b0101);
    serve_one(0, 1'b0, 1'b0, id, res);
    check_output("single_result", 32'(res), 32'h0F);

    $display("[TB] signed operands");
    latency = 2;
    apply_stimulus(1, 4'b1101, 4'b0011);
    serve_one(1, 1'b0, 1'b0, id, res);
    check_output("signed_id", 32'(id), 1);
    check_output("signed_result_a", 32'(res), 32'hF7);
    apply_stimulus(1, 4'b1000, 4'b1000);
    serve_one(0, 1'b0, 1'b0, id, res);
    check_output("signed_result_b", 32'(res), 32'h40);

    $display("[TB] contention");
    pulse_reset();
    latency = 1;
    apply_stimulus(0, 4'($urandom), 4'($urandom));
    apply_stimulus(1, 4'($urandom), 4'($urandom));
    for (int i = 0; i < 4; i++) begin
      serve_one(0, 1'b1, 1'b0, id, res);
      check_output("contention_grant", 32'(id), 32'(i % 2));
    end
    bus.req_valid = '0;

    $display("[TB] backpressure");
    apply_stimulus(1, 4'b0111, 4'b1001);
    serve_one(10, 1'b0, 1'b0, id, res);
    apply_stimulus(0, 4'b0010, 4'b1111);
    serve_one(0, 1'b0, 1'b0, id, res);
    check_output("after_backpressure_grant", 32'(id), 0);

    $display("[TB] timeout");
    never_done = 1'b1;
    apply_stimulus(0, 4'b0101, 4'b0101);
    serve_one(3, 1'b0, 1'b1, id, res);
    never_done = 1'b0;
    late_done = 1'b1;
    tick();
    late_done = 1'b0;
    #1;
    check_output("late_done_busy", 32'(busy), 0);
    check_output("late_done_resp", 32'(bus.resp_valid), 0);

    $display("[TB] reset mid-wait");
    never_done = 1'b1;
    apply_stimulus(0, 4'b0110, 4'b0011);
    #1;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    check_output("midrst_outputs",
                 {bus.req_ready, bus.resp_valid, bus.mult_valid, busy, bus.resp_error},
                 0);
    check_output("midrst_payload",
                 {bus.mult_A, bus.mult_B, bus.resp_id, bus.resp_result}, 0);
    @(negedge clk);
    rst = 1'b0;
    never_done = 1'b0;
    latency = 0;
    model_last = N_REQ - 1;
    apply_stimulus(1, 4'b0011, 4'b0011);
    serve_one(0, 1'b0, 1'b0, id, res);
    check_output("postrst_single_grant", 32'(id), 1);
    pulse_reset();
    apply_stimulus(0, 4'b0001, 4'b1110);
    apply_stimulus(1, 4'b1111, 4'b1111);
    serve_one(0, 1'b0, 1'b0, id, res);
    check_output("postrst_both_grant", 32'(id), 0);
    serve_one(0, 1'b0, 1'b0, id, res);

    $display("[TB] random traffic");
    for (int t = 0; t < 24; t++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (!bus.req_valid[r] && $urandom_range(0, 1) == 1)
          apply_stimulus(r, 4'($urandom), 4'($urandom));
      end
      if (bus.req_valid == '0) begin
        int r0;
        r0 = int'($urandom_range(0, N_REQ - 1));
        apply_stimulus(r0, 4'($urandom), 4'($urandom));
      end
      latency = int'($urandom_range(0, 4));
      serve_one(int'($urandom_range(0, 3)), 1'b0, 1'b0, id, res);
    end
    bus.req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
